alarm_matcher: RTL
==================

// Module: alarm_matcher
// PURPOSE
//  Holds the user alarm setpoint (hour, minute) and compares it against the running time.
//  Emits 1-cycle alarm_trigger pulses into the alarm signal stage (which stretches each pulse
//  into a visible/audible signal). Sits between the timekeeping counters/buttons and that stage.
//  Owns arm/disarm, ringing timeout and optional snooze.
// PARAMETERS
//  DEFAULT_HOUR  7   setpoint hour after reset (0..23)
//  DEFAULT_MIN   0   setpoint minute after reset (0..59)
//  RING_SECONDS  60  sec_ticks spent RINGING before auto-stop (>=1)
//  SNOOZE_MIN    5   snooze delay in minutes (1..59), used only with ALARM_SNOOZE_EN
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous reset, active-high
//  sec_tick       in   1  1-cycle pulse; cur_* already hold the new time in this cycle
//  cur_hour       in   5  current hour, binary 0..23
//  cur_min        in   6  current minute, binary 0..59
//  cur_sec        in   6  current second, binary 0..59
//  set_mode       in   1  level: user is editing the alarm setpoint
//  inc_hour       in   1  1-cycle pulse: setpoint hour +1 (only when set_mode)
//  inc_min        in   1  1-cycle pulse: setpoint minute +1 (only when set_mode)
//  arm_toggle     in   1  1-cycle pulse: arm/disarm
//  stop           in   1  1-cycle pulse: silence ringing, stay armed
//  snooze         in   1  1-cycle pulse: snooze request (ignored without ALARM_SNOOZE_EN)
//  alarm_trigger  out  1  1-cycle pulse to the alarm signal stage
//  alarm_hour     out  5  current setpoint hour
//  alarm_min      out  6  current setpoint minute
//  armed          out  1  high in ARMED, RINGING, SNOOZE
//  ringing        out  1  high in RINGING
// BEHAVIOUR
//  - Reset: state IDLE; alarm_hour=DEFAULT_HOUR, alarm_min=DEFAULT_MIN; alarm_trigger=0,
//    armed=0, ringing=0; ring counter and snooze target cleared. All outputs registered.
//  - States: IDLE, ARMED, RINGING, SNOOZE (SNOOZE only reachable with ALARM_SNOOZE_EN).
//  - Setpoint: inc_hour wraps 23->0, inc_min wraps 59->0 with no carry into hour.
//    Increments are ignored when set_mode=0 and accepted in every state.
//  - Match: ARMED & !set_mode & sec_tick & cur_hour==alarm_hour & cur_min==alarm_min
//    & cur_sec==0. Next cycle: state RINGING, alarm_trigger=1 for 1 cycle, ring counter=0.
//  - RINGING: on each sec_tick, counter+1. If counter reaches RING_SECONDS, go to ARMED
//    with no pulse. Otherwise alarm_trigger pulses on the next cycle, re-triggering the
//    downstream stage once per second.
//  - Priority per cycle: rst > arm_toggle > stop > set_mode rising > snooze > sec_tick events.
//  - arm_toggle: IDLE->ARMED; ARMED/RINGING/SNOOZE->IDLE. Ringing ceases immediately.
//  - stop: RINGING/SNOOZE->ARMED. Ignored in IDLE/ARMED.
//  - set_mode asserted while RINGING/SNOOZE -> ARMED. Matches are suppressed while set_mode=1.
//  - Re-match at the same minute after stop cannot occur: the match requires cur_sec==0.
//  - alarm_trigger never asserts in IDLE, and never asserts on 2 consecutive cycles.
// CONFIGURATION
//  ALARM_SNOOZE_EN defined:
//   - snooze in RINGING -> SNOOZE. The target is latched as (cur_hour, cur_min + SNOOZE_MIN),
//     minute wrap carries into hour, hour wraps 23->0.
//   - In SNOOZE, sec_tick & cur_sec==0 & time==target -> RINGING with pulse and counter=0.
//   - snooze is ignored outside RINGING. The setpoint itself is unchanged.
//  ALARM_SNOOZE_EN undefined: snooze port kept but ignored. No SNOOZE state, no target regs.
// TESTING
//  1. Reset; arm_toggle; drive 07:00:00 with sec_tick -> alarm_trigger 1 cycle later, ringing=1.
//  2. Ringing with RING_SECONDS=3: 3 further sec_ticks -> pulses after ticks 1 and 2 only,
//     then ringing=0, armed=1.
//  3. set_mode=1; 24 inc_hour pulses, 61 inc_min pulses -> alarm_hour=7, alarm_min=1
//     (wraps verified); time 07:01:00 with set_mode=1 -> no pulse.
//  4. Ringing; stop and arm_toggle in the same cycle -> IDLE, armed=0, no further pulses.
//  5. ALARM_SNOOZE_EN, setpoint 23:58: snooze at 23:58:10 -> SNOOZE; pulse again at
//     00:03:00 (hour wrap); without the macro the same stimulus keeps RINGING.
//  6. rst asserted mid-RINGING -> next cycle IDLE, setpoint back to 07:00, alarm_trigger=0.

Source files
------------

// File: rtl/alarm_matcher.sv
// -----------------------------------------------------------------------------
// alarm_matcher
//   Holds the user alarm setpoint (hour, minute) and compares it with the
//   running time. It emits single-cycle alarm_trigger pulses toward the alarm
//   signal stage, which stretches each pulse into a visible/audible signal.
//   It also owns arm/disarm, the ringing timeout and, optionally, snooze.
//
//   Optional feature macro: ALARM_SNOOZE_EN
//     When defined, a snooze pulse while ringing silences the alarm. The alarm
//     rings again SNOOZE_MIN minutes later.
//     When undefined, the snooze port is ignored. There is no SNOOZE state and
//     no target register.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   sec_tick        1-cycle pulse; cur_* already carry the new time
//   cur_hour/min/sec running time (binary)
//   set_mode        level: user is editing the setpoint
//   inc_hour/inc_min setpoint increment pulses (only honoured in set_mode)
//   arm_toggle      arm/disarm pulse
//   stop            silence ringing, stay armed
//   snooze          snooze request (ALARM_SNOOZE_EN only)
//   alarm_trigger   1-cycle pulse to the alarm signal stage
//   alarm_hour/min  current setpoint
//   armed, ringing  status flags (registered)
// -----------------------------------------------------------------------------
module alarm_matcher #(
    parameter int DEFAULT_HOUR = 7,
    parameter int DEFAULT_MIN  = 0,
    parameter int RING_SECONDS = 60,
    parameter int SNOOZE_MIN   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       set_mode,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       arm_toggle,
    input  logic       stop,
    input  logic       snooze,
    output logic       alarm_trigger,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       armed,
    output logic       ringing
);

    localparam int CNT_W = $clog2(RING_SECONDS + 1);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2
    } state_t;
`endif

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   ring_cnt_r;
    logic [CNT_W-1:0]   ring_cnt_s;
    logic [CNT_W-1:0]   ring_cnt_inc_s;
    logic               trig_s;
    logic               set_mode_q_r;
    logic               set_rise_s;
    logic               setpoint_hit_s;

    // Hour increment with 23 -> 0 wrap
    function automatic logic [4:0] hour_next(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    // Minute increment with 59 -> 0 wrap (no carry)
    function automatic logic [5:0] min_next(input logic [5:0] m);
        return (m == 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

    assign set_rise_s     = set_mode & ~set_mode_q_r;
    assign ring_cnt_inc_s = ring_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign setpoint_hit_s = ~set_mode & sec_tick & (cur_sec == 6'd0)
                          & (cur_hour == alarm_hour) & (cur_min == alarm_min);

`ifdef ALARM_SNOOZE_EN
    logic [4:0] tgt_hour_r;
    logic [5:0] tgt_min_r;
    logic [4:0] tgt_hour_s;
    logic [5:0] tgt_min_s;
    logic       snooze_hit_s;

    // Snooze target: minute overflow carries into the hour, hour wraps 23 -> 0
    function automatic logic [10:0] snooze_target(input logic [4:0] h, input logic [5:0] m);
        logic [6:0] sum;
        logic [4:0] hh;
        sum = {1'b0, m} + 7'(SNOOZE_MIN);
        if (sum >= 7'd60) begin
            sum = sum - 7'd60;
            hh  = hour_next(h);
        end else begin
            hh  = h;
        end
        return {hh, sum[5:0]};
    endfunction

    assign snooze_hit_s = ~set_mode & sec_tick & (cur_sec == 6'd0)
                        & (cur_hour == tgt_hour_r) & (cur_min == tgt_min_r);

    // Snooze target register
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_hour_r <= 5'd0;
            tgt_min_r  <= 6'd0;
        end else begin
            tgt_hour_r <= tgt_hour_s;
            tgt_min_r  <= tgt_min_s;
        end
    end
`else
    logic unused_snooze_s;
    assign unused_snooze_s = snooze & (SNOOZE_MIN != 0);
`endif

    // Setpoint editing; accepted in every state while set_mode is high
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_hour <= 5'(DEFAULT_HOUR);
            alarm_min  <= 6'(DEFAULT_MIN);
        end else if (set_mode) begin
            if (inc_hour) alarm_hour <= hour_next(alarm_hour);
            if (inc_min)  alarm_min  <= min_next(alarm_min);
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            ring_cnt_r    <= '0;
            set_mode_q_r  <= 1'b0;
            alarm_trigger <= 1'b0;
            armed         <= 1'b0;
            ringing       <= 1'b0;
        end else begin
            state_r       <= state_s;
            ring_cnt_r    <= ring_cnt_s;
            set_mode_q_r  <= set_mode;
            // back-to-back pulses are never passed downstream
            alarm_trigger <= trig_s & ~alarm_trigger;
            armed         <= (state_s != ST_IDLE);
            ringing       <= (state_s == ST_RINGING);
        end
    end

    // Next-state logic; if/else order encodes the per-cycle event priority
    always_comb begin
        state_s    = state_r;
        ring_cnt_s = ring_cnt_r;
        trig_s     = 1'b0;
`ifdef ALARM_SNOOZE_EN
        tgt_hour_s = tgt_hour_r;
        tgt_min_s  = tgt_min_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (arm_toggle) state_s = ST_ARMED;
                else            state_s = ST_IDLE;
            end
            ST_ARMED: begin
                if (arm_toggle) begin
                    state_s = ST_IDLE;
                end else if (setpoint_hit_s) begin
                    state_s    = ST_RINGING;
                    trig_s     = 1'b1;
                    ring_cnt_s = '0;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_RINGING: begin
                if (arm_toggle) begin
                    state_s = ST_IDLE;
                end else if (stop || set_rise_s) begin
                    state_s = ST_ARMED;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze) begin
                    state_s                 = ST_SNOOZE;
                    {tgt_hour_s, tgt_min_s} = snooze_target(cur_hour, cur_min);
`endif
                end else if (sec_tick) begin
                    ring_cnt_s = ring_cnt_inc_s;
                    if (ring_cnt_inc_s == CNT_W'(RING_SECONDS)) begin
                        state_s = ST_ARMED;
                    end else begin
                        trig_s = 1'b1;
                    end
                end else begin
                    state_s = ST_RINGING;
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                if (arm_toggle) begin
                    state_s = ST_IDLE;
                end else if (stop || set_rise_s) begin
                    state_s = ST_ARMED;
                end else if (snooze_hit_s) begin
                    state_s    = ST_RINGING;
                    trig_s     = 1'b1;
                    ring_cnt_s = '0;
                end else begin
                    state_s = ST_SNOOZE;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

endmodule
